reg_file_arm: RTL and testbench
===============================

// Module: reg_file_arm
// PURPOSE
// - 16 x 32-bit ARM-style general register file for the single-cycle processor datapath.
// - Two asynchronous read ports (Rn/Rm operand sources) and one synchronous write port (result writeback).
// - R15 is the PC: it is reloaded with PC+8 from the fetch stage on every clock edge.
// PARAMETERS
// - DATA_WIDTH  32  register and data-bus width in bits
// - ADDR_WIDTH  4   register address width; number of registers = 2**ADDR_WIDTH = 16
// PORTS
// - clk   in   1           system clock; all state updates on rising edge
// - rst   in   1           synchronous, active-high reset
// - a_1   in   ADDR_WIDTH  read address, port 1
// - a_2   in   ADDR_WIDTH  read address, port 2
// - a_3   in   ADDR_WIDTH  write address (Rd)
// - wd_3  in   DATA_WIDTH  write data (result)
// - r_15  in   DATA_WIDTH  PC+8 value to load into R15 on every cycle
// - we_3  in   1           write enable for port 3
// - rd_1  out  DATA_WIDTH  read data for a_1 (SrcA)
// - rd_2  out  DATA_WIDTH  read data for a_2 (WriteData)
// BEHAVIOUR
// - Storage: R0..R14 general registers, plus R15 register exposed internally as q_r_15.
// - Reset: on rising clk with rst=1, R0..R15 all become 0; rst has priority over all writes.
// - Write: on rising clk, rst=0, we_3=1, a_3 in 0..14 -> R[a_3] <= wd_3. we_3=0 -> no general register changes.
// - R15: on every rising clk with rst=0, R15 <= r_15, regardless of we_3.
// - a_3=15 with we_3=1: the general write is ignored; R15 still takes r_15.
// - Read: rd_1 = R[a_1], rd_2 = R[a_2], purely combinational, with zero-cycle latency from address change.
// - Reading address 15 returns the registered R15 value, i.e. the r_15 sampled at the last edge.
// - Read/write to the same address in the same cycle: the read shows the old value until the edge; the new value is visible after it (no bypass unless enabled below).
// - Both read ports may address the same register simultaneously; both return the same value.
// - Out-of-range addresses are impossible: ADDR_WIDTH bits fully decode 16 entries.
// - Outputs after reset: rd_1 = rd_2 = 0 for any address until written.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined:
//   - When we_3=1, rst=0 and a_3 != 15, a read port whose address equals a_3 returns wd_3 combinationally (write-through forwarding).
//   - A read port addressing 15 returns r_15 combinationally.
// - REGFILE_BYPASS_EN undefined: reads always return the stored register contents, as specified in BEHAVIOUR.
// TESTING
// - Reset: rst=1 for one edge, then read a_1=0, a_2=15 -> rd_1=0, rd_2=0.
// - Write R0: we_3=1, a_3=0, wd_3=0x1, r_15=0x8, then one edge -> R0=0x1, q_r_15=0x8.
// - Write R1 then read: write R1=0x2 (r_15=0xC); next cycle we_3=0, a_1=0, a_2=1, a_3=3, wd_3=0xAAAAAAAA, r_15=0x10.
//   - After the edge: rd_1=0x1, rd_2=0x2, q_r_15=0x10, R3 still 0.
// - Swap ports + write R2: a_1=1, a_2=0, we_3=1, a_3=2, wd_3=0xAAAAAAAA, r_15=0x14.
//   - Immediately: rd_1=0x2, rd_2=0x1. After the edge: q_r_15=0x14.
// - Read R2/R1, no write: a_1=2, a_2=1, we_3=0, a_3=15, wd_3=0xFFFFFFFF, r_15=0x1C.
//   - Result: rd_1=0xAAAAAAAA, rd_2=0x2, q_r_15=0x1C.
// - PC write conflict: we_3=1, a_3=15, wd_3=0x55, r_15=0x20, one edge -> R15=0x20.
//   - Then rst=1 for one edge -> all registers 0.

Source files
------------

// File: rtl/reg_file_arm.sv
// 16 x 32-bit ARM register file: two async read ports, one sync write port, R15 = PC+8.
// Optional write-through forwarding is enabled with `define REGFILE_BYPASS_EN.
module reg_file_arm #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] a_1,
   input  logic [ADDR_WIDTH-1:0] a_2,
   input  logic [ADDR_WIDTH-1:0] a_3,
   input  logic [DATA_WIDTH-1:0] wd_3,
   input  logic [DATA_WIDTH-1:0] r_15,
   input  logic                  we_3,
   output logic [DATA_WIDTH-1:0] rd_1,
   output logic [DATA_WIDTH-1:0] rd_2
);

   localparam int NREG = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PC_ADDR = '1;

   logic [DATA_WIDTH-1:0] gpr [0:NREG-2];
   logic [DATA_WIDTH-1:0] q_r_15;
   logic [DATA_WIDTH-1:0] regs [0:NREG-1];
   logic                  gpr_we;

   // The PC slot is owned by the fetch stage; a general write to it is dropped.
   assign gpr_we = we_3 && (a_3 != PC_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG - 1; i++)
            gpr[i] <= '0;
      end else if (gpr_we) begin
         gpr[a_3] <= wd_3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         q_r_15 <= '0;
      else
         q_r_15 <= r_15;
   end

   always_comb begin
      for (int i = 0; i < NREG - 1; i++)
         regs[i] = gpr[i];
      regs[NREG-1] = q_r_15;
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_1;
   logic fwd_2;

   assign fwd_1 = gpr_we && !rst && (a_1 == a_3);
   assign fwd_2 = gpr_we && !rst && (a_2 == a_3);

   always_comb begin
      rd_1 = regs[a_1];
      rd_2 = regs[a_2];
      if (a_1 == PC_ADDR)
         rd_1 = r_15;
      else if (fwd_1)
         rd_1 = wd_3;
      if (a_2 == PC_ADDR)
         rd_2 = r_15;
      else if (fwd_2)
         rd_2 = wd_3;
   end
`else
   assign rd_1 = regs[a_1];
   assign rd_2 = regs[a_2];
`endif

endmodule

// File: tb/tb_reg_file_arm.sv
// Scoreboard bench for reg_file_arm (default build, no bypass).
module tb_reg_file_arm;

   logic        clk;
   logic        rst;
   logic [3:0]  a_1;
   logic [3:0]  a_2;
   logic [3:0]  a_3;
   logic [31:0] wd_3;
   logic [31:0] r_15;
   logic        we_3;
   logic [31:0] rd_1;
   logic [31:0] rd_2;

   typedef struct {
      string       nm;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   reg_file_arm #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .a_1  (a_1),
      .a_2  (a_2),
      .a_3  (a_3),
      .wd_3 (wd_3),
      .r_15 (r_15),
      .we_3 (we_3),
      .rd_1 (rd_1),
      .rd_2 (rd_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: read ports are sampled mid-cycle, after inputs settle.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         if (rd_1 !== mon_e.e1) begin
            n_bad++;
            $display("FAIL %s rd_1: got %h want %h", mon_e.nm, rd_1, mon_e.e1);
         end
         n_cmp++;
         if (rd_2 !== mon_e.e2) begin
            n_bad++;
            $display("FAIL %s rd_2: got %h want %h", mon_e.nm, rd_2, mon_e.e2);
         end
      end
   end

   task automatic drive(input string nm, input logic r,
                        input logic [3:0] x1, input logic [3:0] x2,
                        input logic w, input logic [3:0] x3,
                        input logic [31:0] wd, input logic [31:0] pc,
                        input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      rst  = r;
      a_1  = x1;
      a_2  = x2;
      we_3 = w;
      a_3  = x3;
      wd_3 = wd;
      r_15 = pc;
      e.nm = nm;
      e.e1 = e1;
      e.e2 = e2;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      a_1  = '0;
      a_2  = '0;
      a_3  = '0;
      wd_3 = '0;
      r_15 = '0;
      we_3 = 1'b0;
      @(posedge clk);
      #1;
      //     name        rst a_1 a_2 we a_3 wd_3          r_15          rd_1          rd_2
      drive("reset",     0, 0,  15, 1, 0,  32'h1,        32'h8,        32'h0,        32'h0);
      drive("w_r0",      0, 0,  15, 1, 1,  32'h2,        32'hC,        32'h1,        32'h8);
      drive("rd_r0_r1",  0, 0,  1,  0, 3,  32'hAAAAAAAA, 32'h10,       32'h1,        32'h2);
      drive("r3_pc",     0, 3,  15, 0, 3,  32'hAAAAAAAA, 32'h10,       32'h0,        32'h10);
      drive("swap_w_r2", 0, 1,  0,  1, 2,  32'hAAAAAAAA, 32'h14,       32'h2,        32'h1);
      drive("r2_pc",     0, 2,  15, 0, 15, 32'hFFFFFFFF, 32'h1C,       32'hAAAAAAAA, 32'h14);
      drive("r2_r1",     0, 2,  1,  0, 15, 32'hFFFFFFFF, 32'h1C,       32'hAAAAAAAA, 32'h2);
      drive("pc_wr",     0, 15, 15, 1, 15, 32'h55,       32'h20,       32'h1C,       32'h1C);
      drive("pc_after",  0, 15, 14, 0, 15, 32'h55,       32'h20,       32'h20,       32'h0);
      drive("rw_same",   0, 5,  5,  1, 5,  32'h12345678, 32'h24,       32'h0,        32'h0);
      drive("w_r14",     0, 5,  5,  1, 14, 32'hDEADBEEF, 32'h24,       32'h12345678, 32'h12345678);
      drive("r14_r0",    0, 14, 0,  0, 14, 32'h0,        32'h24,       32'hDEADBEEF, 32'h1);
      drive("rst_prio",  1, 14, 0,  1, 0,  32'h99,       32'h24,       32'hDEADBEEF, 32'h1);
      drive("post_rst",  0, 14, 15, 0, 0,  32'h0,        32'h28,       32'h0,        32'h0);
      drive("post_rst2", 0, 15, 0,  0, 0,  32'h0,        32'h28,       32'h28,       32'h0);
      drive("post_rst3", 0, 5,  2,  0, 0,  32'h0,        32'h28,       32'h0,        32'h0);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(posedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d checks left unserviced, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not end, want finish");
      $fatal(1, "timeout");
   end

endmodule
